tr5_i2c_pad_conditioner: RTL and testbench

Open-drain pad stage that sits directly downstream of the SCL/SDA bit-bang PIOs on the QSYS Avalon bus. It turns PIO levels into open-drain output enables and synchronizes and glitch-filters the pad inputs. It also tracks slave clock stretching, with a timeout, and detects START/STOP. Status is exposed on a small zero-wait Avalon-MM slave, so software can poll bus state without sampling raw pads.

---
 rtl/tr5_i2c_pad_pkg.sv | 26 ++
 rtl/tr5_i2c_pad_conditioner_if.sv | 22 ++
 rtl/tr5_i2c_line_filter.sv | 43 ++++
 rtl/tr5_i2c_pad_conditioner.sv | 224 ++++++++++++++++++++++
 tb/tb_tr5_i2c_pad_conditioner.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tr5_i2c_pad_pkg.sv
// Shared definitions for the I2C pad conditioner: register map, STATUS bit
// positions and the clock-stretch tracker state encoding.
package tr5_i2c_pad_pkg;

    // Avalon-MM register addresses
    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_COUNT  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    // STATUS register bit positions
    localparam int ST_SCL     = 0;
    localparam int ST_SDA     = 1;
    localparam int ST_STRETCH = 2;
    localparam int ST_TO      = 3;
    localparam int ST_START   = 4;
    localparam int ST_STOP    = 5;
    localparam int ST_BUSY    = 6;

    // Clock-stretch tracker states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        TIMEOUT   = 2'd2
    } stretch_state_e;

endpackage

// File: rtl/tr5_i2c_pad_conditioner_if.sv
// Zero-wait Avalon-MM status slave bundle of the I2C pad conditioner.
// Handshake: a write happens on every clk edge where chipselect=1 and
// write_n=0; reads have no strobe -- readdata is a combinational function of
// address and is valid in the same cycle. irq is a level output.
interface tr5_i2c_pad_conditioner_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/tr5_i2c_line_filter.sv
// One pad input line: 2-FF synchronizer followed by a glitch filter. The
// filtered level only moves after FILT_LEN consecutive synchronized samples
// disagree with it; any agreeing sample restarts the run.
module tr5_i2c_line_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pad_in,
    output logic filt
);
    localparam int CW = $clog2(FILT_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] run_cnt;

    // Two-stage synchronizer; idles at the released (high) level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pad_in;
            sync2 <= sync1;
        end
    end

    // Count disagreeing samples; flip the filtered level on the FILT_LEN-th one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt    <= 1'b1;
            run_cnt <= '0;
        end else if (sync2 == filt) begin
            run_cnt <= '0;
        end else if (run_cnt == CW'(FILT_LEN - 1)) begin
            filt    <= sync2;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/tr5_i2c_pad_conditioner.sv
// Open-drain pad stage for bit-banged SCL/SDA: output enables, filtered pad
// levels, clock-stretch tracking, START/STOP detection and an Avalon-MM
// status slave. Optional feature macro: TR5_I2C_STRETCH_TO_EN enables the
// stretch timeout (TIMEOUT state, STATUS.TO and irq).
module tr5_i2c_pad_conditioner
    import tr5_i2c_pad_pkg::*;
#(
    parameter int FILT_LEN   = 4,
    parameter int STRETCH_TO = 50000,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       scl_out_port,
    input  logic                       sda_out_port,
    input  logic                       scl_pad_in,
    input  logic                       sda_pad_in,
    output logic                       scl_pad_oe,
    output logic                       sda_pad_oe,
    output logic                       scl_filt,
    output logic                       sda_filt,
    tr5_i2c_pad_conditioner_if.slave   avs,
    output stretch_state_e             dbg_state
);
    // Pad data is tied low, so a PIO 0 means pull the line down
    assign scl_pad_oe = ~scl_out_port;
    assign sda_pad_oe = ~sda_out_port;

    tr5_i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filter (
        .clk    (clk),
        .reset  (reset),
        .pad_in (scl_pad_in),
        .filt   (scl_filt)
    );

    tr5_i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filter (
        .clk    (clk),
        .reset  (reset),
        .pad_in (sda_pad_in),
        .filt   (sda_filt)
    );

    logic wr_en;
    logic wr_status;
    logic wr_ctrl;
    assign wr_en     = avs.chipselect & ~avs.write_n;
    assign wr_status = wr_en && (avs.address == ADDR_STATUS);
    assign wr_ctrl   = wr_en && (avs.address == ADDR_CTRL);

    stretch_state_e   state_q;
    stretch_state_e   state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] count_q;
    logic             capture;
    logic             stretching;
    logic             to_q;
    logic             irq_en_q;

    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign stretching = (state_q != IDLE);
    assign dbg_state  = state_q;

`ifdef TR5_I2C_STRETCH_TO_EN
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(STRETCH_TO);
    logic to_set;
`endif

    // Stretch tracker state, running counter and captured stretch length
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                count_q <= cnt_d;
            end
        end
    end

    // Stretch tracker next state: the counter holds the number of cycles
    // spent in WAIT_HIGH, so a normal exit captures the full stretch length
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
`ifdef TR5_I2C_STRETCH_TO_EN
        to_set  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (scl_out_port && !scl_filt) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                cnt_d = cnt_inc;
                if (!scl_out_port) begin
                    state_d = IDLE;
                end else if (scl_filt) begin
                    state_d = IDLE;
                    capture = 1'b1;
                end
`ifdef TR5_I2C_STRETCH_TO_EN
                else if (cnt_inc == TO_VAL) begin
                    state_d = TIMEOUT;
                    to_set  = 1'b1;
                end
`endif
            end
            TIMEOUT: begin
                if (scl_filt || !scl_out_port) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // START/STOP need SCL high on both sides of the SDA edge
    logic scl_prev;
    logic sda_prev;
    logic scl_steady_high;
    logic start_evt;
    logic stop_evt;
    logic start_q;
    logic stop_q;
    logic busy_q;

    assign scl_steady_high = scl_prev & scl_filt;
    assign start_evt       = scl_steady_high & sda_prev & ~sda_filt;
    assign stop_evt        = scl_steady_high & ~sda_prev & sda_filt;

    // Bus condition flags, busy tracking and CTRL register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            busy_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            scl_prev <= scl_filt;
            sda_prev <= sda_filt;
            if (start_evt) begin
                start_q <= 1'b1;
            end else if (wr_status && avs.writedata[ST_START]) begin
                start_q <= 1'b0;
            end
            if (stop_evt) begin
                stop_q <= 1'b1;
            end else if (wr_status && avs.writedata[ST_STOP]) begin
                stop_q <= 1'b0;
            end
            if (start_evt) begin
                busy_q <= 1'b1;
            end else if (stop_evt) begin
                busy_q <= 1'b0;
            end
            if (wr_ctrl) begin
                irq_en_q <= avs.writedata[0];
            end
        end
    end

`ifdef TR5_I2C_STRETCH_TO_EN
    logic irq_q;

    // Sticky timeout flag and registered interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (to_set) begin
                to_q <= 1'b1;
            end else if (wr_status && avs.writedata[ST_TO]) begin
                to_q <= 1'b0;
            end
            irq_q <= to_q & irq_en_q;
        end
    end

    assign avs.irq = irq_q;

    logic unused_wdata;
    assign unused_wdata = ^{avs.writedata[31:6], avs.writedata[2:1]};
`else
    assign to_q    = 1'b0;
    assign avs.irq = 1'b0;

    logic unused_cfg;
    assign unused_cfg = ^{avs.writedata[31:6], avs.writedata[3:1], (STRETCH_TO != 0)};
`endif

    logic [31:0] rdata;

    // Zero-wait register read mux
    always_comb begin
        rdata = '0;
        case (avs.address)
            ADDR_STATUS: begin
                rdata[ST_SCL]     = scl_filt;
                rdata[ST_SDA]     = sda_filt;
                rdata[ST_STRETCH] = stretching;
                rdata[ST_TO]      = to_q;
                rdata[ST_START]   = start_q;
                rdata[ST_STOP]    = stop_q;
                rdata[ST_BUSY]    = busy_q;
            end
            ADDR_COUNT: rdata[CNT_W-1:0] = count_q;
            ADDR_CTRL:  rdata[0]         = irq_en_q;
            default:    rdata            = '0;
        endcase
    end

    assign avs.readdata = rdata;
endmodule

// File: tb/tb_tr5_i2c_pad_conditioner.sv
// Self-checking bench for tr5_i2c_pad_conditioner (FILT_LEN=4, STRETCH_TO=50).
// Honours TR5_I2C_STRETCH_TO_EN the same way the design does.
module tb_tr5_i2c_pad_conditioner;
    import tr5_i2c_pad_pkg::*;

    localparam int FILT_LEN   = 4;
    localparam int STRETCH_TO = 50;
    localparam int CNT_W      = 16;
    localparam int LAT        = FILT_LEN + 2;

`ifdef TR5_I2C_STRETCH_TO_EN
    localparam logic TO_ON = 1'b1;
`else
    localparam logic TO_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           scl_out_port;
    logic           sda_out_port;
    logic           scl_pad_in;
    logic           sda_pad_in;
    logic           scl_pad_oe;
    logic           sda_pad_oe;
    logic           scl_filt;
    logic           sda_filt;
    stretch_state_e dbg_state;

    tr5_i2c_pad_conditioner_if avs_if ();

    tr5_i2c_pad_conditioner #(
        .FILT_LEN   (FILT_LEN),
        .STRETCH_TO (STRETCH_TO),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .scl_out_port (scl_out_port),
        .sda_out_port (sda_out_port),
        .scl_pad_in   (scl_pad_in),
        .sda_pad_in   (sda_pad_in),
        .scl_pad_oe   (scl_pad_oe),
        .sda_pad_oe   (sda_pad_oe),
        .scl_filt     (scl_filt),
        .sda_filt     (sda_filt),
        .avs          (avs_if),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_scl, m_sda;
    logic        m_start, m_stop, m_busy;
    logic        scl_h[$];
    logic        sda_h[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A filtered line adopts a level once the last FILT_LEN pad samples,
    // seen two clocks late through the synchronizer, all show that level.
    function automatic logic window_unanimous(input logic h[$], input logic v);
        for (int j = 0; j < FILT_LEN; j++) begin
            if (h[h.size() - 3 - j] !== v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status(input logic stretch);
        logic [31:0] s;
        s = '0;
        s[ST_SCL]     = m_scl;
        s[ST_SDA]     = m_sda;
        s[ST_STRETCH] = stretch;
        s[ST_START]   = m_start;
        s[ST_STOP]    = m_stop;
        s[ST_BUSY]    = m_busy;
        return s;
    endfunction

    task automatic model_reset();
        m_scl = 1'b1; m_sda = 1'b1;
        m_start = 1'b0; m_stop = 1'b0; m_busy = 1'b0;
        scl_h.delete(); sda_h.delete();
        for (int i = 0; i < LAT; i++) begin
            scl_h.push_back(1'b1);
            sda_h.push_back(1'b1);
        end
    endtask

    // One clock: advance the model with the sampled pads and check both filters
    task automatic step();
        logic p_scl, p_sda;
        scl_h.push_back(scl_pad_in);
        sda_h.push_back(sda_pad_in);
        @(posedge clk);
        #1;
        p_scl = m_scl;
        p_sda = m_sda;
        if (window_unanimous(scl_h, !m_scl)) m_scl = !m_scl;
        if (window_unanimous(sda_h, !m_sda)) m_sda = !m_sda;
        if (scl_h.size() > 32) begin
            void'(scl_h.pop_front());
            void'(sda_h.pop_front());
        end
        if (p_scl && m_scl && p_sda && !m_sda) begin m_start = 1'b1; m_busy = 1'b1; end
        if (p_scl && m_scl && !p_sda && m_sda) begin m_stop = 1'b1; m_busy = 1'b0; end
        check("scl_filt", scl_filt, m_scl);
        check("sda_filt", sda_filt, m_sda);
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        avs_if.address    = a;
        avs_if.chipselect = 1'b1;
        avs_if.write_n    = 1'b1;
        #1;
        d = avs_if.readdata;
        avs_if.chipselect = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        avs_if.address    = a;
        avs_if.writedata  = d;
        avs_if.chipselect = 1'b1;
        avs_if.write_n    = 1'b0;
        step();
        avs_if.chipselect = 1'b0;
        avs_if.write_n    = 1'b1;
        if (a == ADDR_STATUS) begin
            if (d[ST_START]) m_start = 1'b0;
            if (d[ST_STOP])  m_stop  = 1'b0;
        end
    endtask

    // Master releases SCL while the pad is held low for hold cycles
    task automatic run_stretch(input int hold);
        logic [31:0] st;
        logic [31:0] cnt;
        int          stretched;
        scl_out_port = 1'b0;
        scl_pad_in   = 1'b0;
        repeat (LAT + 2) step();
        scl_out_port = 1'b1;
        stretched = 0;
        repeat (hold) begin
            step();
            read_reg(ADDR_STATUS, st);
            if (st[ST_STRETCH]) stretched++;
        end
        scl_pad_in = 1'b1;
        repeat (LAT + 6) begin
            step();
            read_reg(ADDR_STATUS, st);
            if (st[ST_STRETCH]) stretched++;
        end
        check("stretch_cycles", stretched, hold + LAT);
        exp_q.push_back(32'(hold + LAT));
        read_reg(ADDR_COUNT, cnt);
        check("stretch_count", cnt, exp_q.pop_front());
        last_count = cnt;
        check("stretch_idle", 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        logic [31:0] rd;
        logic        v;

        reset = 1'b1;
        scl_out_port = 1'b0; sda_out_port = 1'b1;
        scl_pad_in = 1'b1; sda_pad_in = 1'b1;
        avs_if.address = '0; avs_if.chipselect = 1'b0;
        avs_if.write_n = 1'b1; avs_if.writedata = '0;
        last_count = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("oe_scl_in_reset", scl_pad_oe, 1'b1);
        check("oe_sda_in_reset", sda_pad_oe, 1'b0);
        check("irq_reset", avs_if.irq, 1'b0);
        check("state_reset", 32'(dbg_state), 32'(IDLE));
        read_reg(ADDR_STATUS, rd);
        check("status_reset", rd, 32'h03);
        read_reg(ADDR_COUNT, rd);
        check("count_reset", rd, 32'h0);
        read_reg(ADDR_CTRL, rd);
        check("ctrl_reset", rd, 32'h0);
        read_reg(2'd3, rd);
        check("addr3_zero", rd, 32'h0);
        scl_out_port = 1'b1;
        #1;
        check("oe_scl_release", scl_pad_oe, 1'b0);
        reset = 1'b0;

        // Short SDA glitch is filtered out
        sda_pad_in = 1'b0;
        repeat (3) step();
        sda_pad_in = 1'b1;
        repeat (8) step();
        check("glitch_ignored", sda_filt, 1'b1);

        // Clean SDA fall with SCL high: START, latency FILT_LEN+2 edges
        sda_pad_in = 1'b0;
        repeat (LAT - 1) step();
        check("sda_hold_before", sda_filt, 1'b1);
        step();
        check("sda_fall_edge", sda_filt, 1'b0);
        repeat (3) step();
        read_reg(ADDR_STATUS, rd);
        check("start_status", rd, 32'h51);
        sda_pad_in = 1'b1;
        repeat (LAT + 3) step();
        read_reg(ADDR_STATUS, rd);
        check("stop_status", rd, 32'h33);
        write_reg(ADDR_STATUS, 32'h30);
        read_reg(ADDR_STATUS, rd);
        check("w1c_status", rd, 32'h03);

        // Random SDA pulse train with SCL high
        v = 1'b0;
        for (int r = 0; r < 30; r++) begin
            sda_pad_in = v;
            repeat ($urandom_range(1, 8)) step();
            v = !v;
        end
        sda_pad_in = 1'b1;
        repeat (LAT + 4) step();
        read_reg(ADDR_STATUS, rd);
        check("rand_sda_status", rd, exp_status(1'b0));
        write_reg(ADDR_STATUS, 32'h38);
        read_reg(ADDR_STATUS, rd);
        check("rand_sda_clear", rd, exp_status(1'b0));

        // Both pads toggled together: never a START/STOP
        v = 1'b0;
        for (int r = 0; r < 30; r++) begin
            scl_pad_in = v;
            sda_pad_in = v;
            repeat ($urandom_range(1, 10)) step();
            v = !v;
        end
        scl_pad_in = 1'b1;
        sda_pad_in = 1'b1;
        repeat (LAT + 4) step();
        read_reg(ADDR_STATUS, rd);
        check("same_edge_model", rd, exp_status(1'b0));
        check("same_edge_none", rd, 32'h03);

        // Clock stretching with captured length
        for (int r = 0; r < 3; r++) run_stretch($urandom_range(10, 40));
`ifndef TR5_I2C_STRETCH_TO_EN
        run_stretch(100);
        check("stretch_106", last_count, 32'd106);
`endif

        // Stretch timeout and interrupt
        write_reg(ADDR_CTRL, 32'h1);
        read_reg(ADDR_CTRL, rd);
        check("ctrl_irq_en", rd, 32'h1);
        scl_out_port = 1'b0;
        scl_pad_in   = 1'b0;
        repeat (LAT + 2) step();
        scl_out_port = 1'b1;
        repeat (STRETCH_TO) step();
        read_reg(ADDR_STATUS, rd);
        check("to_before", rd[ST_TO], 1'b0);
        check("stretching_before_to", rd[ST_STRETCH], 1'b1);
        step();
        read_reg(ADDR_STATUS, rd);
        check("to_set", rd[ST_TO], TO_ON);
        check("irq_not_yet", avs_if.irq, 1'b0);
        check("to_state", 32'(dbg_state), TO_ON ? 32'(TIMEOUT) : 32'(WAIT_HIGH));
        step();
        check("irq_rise", avs_if.irq, TO_ON);
        write_reg(ADDR_STATUS, 32'h08);
        read_reg(ADDR_STATUS, rd);
        check("to_cleared", rd[ST_TO], 1'b0);
        check("irq_lag", avs_if.irq, TO_ON);
        step();
        check("irq_fall", avs_if.irq, 1'b0);
        scl_pad_in = 1'b1;
        repeat (LAT + 6) step();
        read_reg(ADDR_COUNT, rd);
        check("to_count", rd, TO_ON ? last_count : 32'(STRETCH_TO + 4 + LAT));
        check("to_exit_idle", 32'(dbg_state), 32'(IDLE));
        write_reg(ADDR_CTRL, 32'h0);

        // Reset during a stretch aborts without capture
        scl_out_port = 1'b0;
        scl_pad_in   = 1'b0;
        repeat (LAT + 2) step();
        scl_out_port = 1'b1;
        repeat (10) step();
        check("mid_stretch_state", 32'(dbg_state), 32'(WAIT_HIGH));
        reset = 1'b1;
        #1;
        check("reset_abort_state", 32'(dbg_state), 32'(IDLE));
        scl_pad_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (LAT + 2) step();
        read_reg(ADDR_COUNT, rd);
        check("reset_no_capture", rd, 32'h0);
        read_reg(ADDR_STATUS, rd);
        check("reset_status", rd, 32'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
